// File: rtl/fm_discriminator_if.sv
// fm_discriminator_if: I/Q sample handshake in, recovered phase increment out
interface fm_discriminator_if #(
  parameter int NBITS_SAMPLE = 16
);
  logic                           in_valid;
  logic                           in_ready;
  logic signed [NBITS_SAMPLE-1:0] in_i;
  logic signed [NBITS_SAMPLE-1:0] in_q;
  logic                           out_valid;
  logic [31:0]                    outinc;
  modport master (output in_valid, in_i, in_q, input in_ready, out_valid, outinc);
  modport slave (input in_valid, in_i, in_q, output in_ready, out_valid, outinc);
endinterface

// File: rtl/fm_discriminator.sv
// fm_discriminator: CORDIC-vectoring FM demodulator; define FM_DISCRIMINATOR_AVG4_EN for a 4-tap moving average on outinc
module fm_discriminator #(
  parameter int NBITS_SAMPLE = 16,
  parameter int NBITS_PHASE  = 16,
  parameter int NITER        = 14
) (
  input logic               clock,
  input logic               reset,
  fm_discriminator_if.slave bus
);
  localparam int W = NBITS_SAMPLE + 2;
  localparam logic [31:0] ATAN32 [32] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4, 32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC, 32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518, 32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005, 32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000};
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_DIFF} state_t;
  state_t                         r_state, w_next;
  logic [4:0]                     r_k;
  logic signed [NBITS_SAMPLE-1:0] r_in_i, r_in_q;
  logic signed [W-1:0]            r_i, r_q, w_ext_i, w_ext_q, w_di, w_dq;
  logic [NBITS_PHASE-1:0]         r_z, r_prev, w_atan;
  logic signed [NBITS_PHASE-1:0]  w_inc, w_res;
  logic                           r_first, r_out_valid, w_accept, w_zero, w_neg, w_qneg;
  logic [31:0]                    r_outinc;

  // atan(2^-k) rescaled from a 32-bit turn to NBITS_PHASE with rounding
  function automatic logic [NBITS_PHASE-1:0] f_atan(input logic [4:0] k);
    logic [32:0] t;
    t = {ATAN32[k], 1'b0} + (33'd1 << (32 - NBITS_PHASE));
    return NBITS_PHASE'(t >> (33 - NBITS_PHASE));
  endfunction

  assign bus.in_ready  = r_state == S_IDLE;
  assign bus.out_valid = r_out_valid;
  assign bus.outinc    = r_outinc;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_ext_i       = W'(r_in_i);
  assign w_ext_q       = W'(r_in_q);
  assign w_neg         = r_in_i[NBITS_SAMPLE-1];
  assign w_zero        = r_in_i == '0 && r_in_q == '0;
  assign w_qneg        = r_q[W-1];
  assign w_di          = r_i >>> r_k;
  assign w_dq          = r_q >>> r_k;
  assign w_atan        = f_atan(r_k);
  assign w_inc         = w_zero ? '0 : $signed(r_z - r_prev);

`ifdef FM_DISCRIMINATOR_AVG4_EN
  logic signed [NBITS_PHASE-1:0] r_win [3];
  logic signed [NBITS_PHASE+1:0] w_sum;
  assign w_sum = (NBITS_PHASE+2)'(w_inc) + (NBITS_PHASE+2)'(r_win[0]) + (NBITS_PHASE+2)'(r_win[1]) + (NBITS_PHASE+2)'(r_win[2]);
  assign w_res = NBITS_PHASE'(w_sum >>> 2);
  // history of the three previous increments, emptied whenever a new phase reference starts
  always_ff @(posedge clock)
    if (reset || (r_state == S_DIFF && r_first)) r_win <= '{default: '0};
    else if (r_state == S_DIFF) r_win <= '{w_inc, r_win[0], r_win[1]};
`else
  assign w_res = w_inc;
`endif

  // state register
  always_ff @(posedge clock)
    r_state <= reset ? S_IDLE : w_next;

  // next-state: one pre-rotation cycle, NITER micro-rotations, one differencing cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = w_accept ? S_PRE : S_IDLE;
      S_PRE:  w_next = S_ITER;
      S_ITER: w_next = r_k == 5'(NITER - 1) ? S_DIFF : S_ITER;
      S_DIFF: w_next = S_IDLE;
    endcase
  end

  // datapath: capture, CORDIC vectoring, phase differencing and output register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_first     <= 1'b1;
      r_prev      <= '0;
      r_outinc    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_in_i <= bus.in_i;
        r_in_q <= bus.in_q;
      end
      if (r_state == S_PRE) begin
        r_i <= w_neg ? -w_ext_i : w_ext_i;
        r_q <= w_neg ? -w_ext_q : w_ext_q;
        r_z <= w_neg ? {1'b1, {(NBITS_PHASE-1){1'b0}}} : '0;
        r_k <= '0;
      end
      if (r_state == S_ITER) begin
        r_i <= w_qneg ? r_i - w_dq : r_i + w_dq;
        r_q <= w_qneg ? r_q + w_di : r_q - w_di;
        r_z <= w_qneg ? r_z - w_atan : r_z + w_atan;
        r_k <= r_k + 5'd1;
      end
      if (r_state == S_DIFF) begin
        r_first <= 1'b0;
        if (!w_zero) r_prev <= r_z;
        if (!r_first) begin
          r_out_valid <= 1'b1;
          r_outinc    <= 32'(w_res);
        end
      end
    end
  end
endmodule

// File: tb/tb_fm_discriminator.sv
// tb_fm_discriminator: directed-vector bench for fm_discriminator
module tb_fm_discriminator;
  localparam int NITER = 14;
`ifdef FM_DISCRIMINATOR_AVG4_EN
  localparam int ZTOL = 4;
`else
  localparam int ZTOL = 0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   win[4] = '{default: 0};

  fm_discriminator_if #(.NBITS_SAMPLE(16)) bus ();
  fm_discriminator #(.NBITS_SAMPLE(16), .NBITS_PHASE(16), .NITER(NITER)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
    int d;
    d = obs - exp;
    n_tests++;
    if (d > tol || d < -tol) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int model(input int raw);
`ifdef FM_DISCRIMINATOR_AVG4_EN
    win = '{raw, win[0], win[1], win[2]};
    return (win[0] + win[1] + win[2] + win[3]) >>> 2;
`else
    return raw;
`endif
  endfunction

  function automatic logic signed [15:0] iq(input int ph, input bit sine);
    real a;
    a = 2.0 * 3.14159265358979 * real'(ph) / 65536.0;
    return 16'($rtoi($floor(16384.0 * (sine ? $sin(a) : $cos(a)) + 0.5)));
  endfunction

  task automatic xact(input string tag, input logic signed [15:0] i, input logic signed [15:0] q,
                      input bit first, input int raw, input int tol);
    int          lat;
    int          nstrb;
    logic [31:0] got;
    lat = 0;
    nstrb = 0;
    got = '0;
    @(negedge clock);
    for (int c = 0; c < 40 && !bus.in_ready; c++) @(negedge clock);
    if (!bus.in_ready) check({tag, "_ready"}, 0, 1);
    bus.in_i = i;
    bus.in_q = q;
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_i = 16'($urandom);
    bus.in_q = 16'($urandom);
    for (int c = 1; c <= NITER + 4; c++) begin
      @(posedge clock);
      #1;
      if (bus.out_valid) begin
        nstrb++;
        lat = c;
        got = bus.outinc;
      end
    end
    if (first) begin
      win = '{default: 0};
      check({tag, "_nostrobe"}, nstrb, 0);
      check({tag, "_held"}, int'(bus.outinc), 0);
    end else begin
      check({tag, "_strobes"}, nstrb, 1);
      check({tag, "_latency"}, lat, NITER + 2);
      check(tag, int'(got), model(raw), tol);
    end
  endtask

  task automatic xph(input string tag, input int ph, input bit first, input int raw);
    xact(tag, iq(ph, 1'b0), iq(ph, 1'b1), first, raw, 4);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", int'(bus.in_ready), 1);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_outinc", int'(bus.outinc), 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int nstrb;
    bus.in_valid = 1'b0;
    bus.in_i = '0;
    bus.in_q = '0;
    do_reset();
    xph("first", 16'h0000, 1'b1, 0);
    xph("up1", 16'h0400, 1'b0, 16'h0400);
    xph("up2", 16'h0800, 1'b0, 16'h0400);
    xph("up3", 16'h0C00, 1'b0, 16'h0400);
    xph("dn1", 16'h0B00, 1'b0, -256);
    xph("dn2", 16'h0A00, 1'b0, -256);
    xph("big", 16'h7F00, 1'b0, 16'h7500);
    xph("wrap", 16'h8100, 1'b0, 16'h0200);
    xact("ref", 16'sh4000, 16'sh0000, 1'b0, 16'h7F00, 4);
    xact("zero", 16'sh0000, 16'sh0000, 1'b0, 0, ZTOL);
    xact("quad", 16'sh0000, 16'sh4000, 1'b0, 16'h4000, 4);
    xact("fullneg", -16'sd32768, 16'sh0000, 1'b0, 16'h4000, 4);
    // abort in the 5th ITER cycle
    @(negedge clock);
    bus.in_i = iq(16'h2000, 1'b0);
    bus.in_q = iq(16'h2000, 1'b1);
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_ready", int'(bus.in_ready), 1);
    check("abort_outinc", int'(bus.outinc), 0);
    @(negedge clock);
    reset = 1'b0;
    nstrb = 0;
    for (int c = 0; c < NITER + 4; c++) begin
      @(posedge clock);
      #1;
      if (bus.out_valid) nstrb++;
    end
    check("abort_nostrobe", nstrb, 0);
    xph("abort_first", 16'h1000, 1'b1, 0);
    xph("abort_next", 16'h1300, 1'b0, 16'h0300);
    do_reset();
    xph("avg_first", 16'h0000, 1'b1, 0);
    xph("avg1", 16'h0100, 1'b0, 16'h0100);
    xph("avg2", 16'h0200, 1'b0, 16'h0100);
    xph("avg3", 16'h0300, 1'b0, 16'h0100);
    xph("avg4", 16'h0800, 1'b0, 16'h0500);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
